length_playback: RTL and testbench
==================================

# length_playback

Consumer side of the button-driven length counter. On a start pulse it latches the current 7-bit length and plays it out as that many evenly spaced pixel-enable strobes, each tagged with its index. When playback finishes it issues a one-cycle `sync` pulse, which clears the length counter for the next entry. It sits between the length counter and the image-generation datapath.

## Interface
- `TICK_DIV`, default 4: clock cycles per output pixel; legal range 1..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request pulse, already synchronized and edge-detected upstream.
- `curr_length`  in  7  number of pixels to play (0..127); sampled only when a start is accepted.
- `pixel_en`  out  1  one-cycle strobe per played pixel.
- `pixel_idx`  out  7  index of the current pixel (0..len-1); valid while `pixel_en`=1.
- `busy`  out  1  high while a playback is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse at the end of playback.
- `sync`  out  1  one-cycle clear pulse to the length counter; coincident with `done`.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, DONE}.
  - `len` (7 b): latched length.
  - `idx` (7 b): pixel index.
  - `div` (width = clog2(TICK_DIV), minimum 1 bit): prescaler.
- Reset (async, `nrst`=0): `state`=IDLE; `len`, `idx`, `div` = 0. All outputs are 0 during reset and in the first cycle after release.
- IDLE:
  - `start`=1 and `curr_length`≠0: latch `len`=`curr_length`; set `idx`=0, `div`=0; go to RUN.
  - `start`=1 and `curr_length`=0: go directly to DONE. No pixels are played.
  - Otherwise stay in IDLE.
- RUN:
  - `div` counts 0..TICK_DIV-1 and wraps to 0.
  - `pixel_en` = (`state`==RUN && `div`==TICK_DIV-1).
  - `pixel_idx` = `idx` at all times. It is meaningful only while `pixel_en`=1.
  - On a cycle with `pixel_en`=1:
    - If `idx`==`len`-1, go to DONE.
    - Otherwise `idx` ← `idx`+1.
- DONE: `sync`=1 and `done`=1 for exactly this one cycle; then return to IDLE.
- `start` is ignored in RUN and DONE. It is not queued.
- `curr_length` changes after the start is accepted have no effect, because `len` is latched.
- `idx` never exceeds `len`-1 (126 max), so there is no 7-bit overflow.
- All outputs decode only from registered state and counters: no combinational path from any input to any output.
- Reset asserted mid-playback aborts immediately: return to IDLE, no `sync`, no `done`.

## Timing
- Cycle numbering: the cycle in which `start` is high and is sampled in IDLE is cycle 0.
- Non-zero length L:
  - `busy`=1 in cycles 1..L·TICK_DIV+1.
  - `pixel_en` pulses in cycles k·TICK_DIV for k = 1..L, with `pixel_idx`=k-1.
  - `sync`/`done` assert in cycle L·TICK_DIV+1.
  - The block is back in IDLE in cycle L·TICK_DIV+2, where a new `start` is accepted.
- Zero length: `busy`, `sync` and `done` are high in cycle 1 only; no `pixel_en`.
- TICK_DIV=1: `pixel_en` is high continuously in cycles 1..L.
- Start-to-sync latency is L·TICK_DIV+1 cycles.
- Back-to-back minimum spacing between accepted starts is L·TICK_DIV+2 cycles.

## Test plan
- Basic playback, TICK_DIV=4: `curr_length`=3, `start` pulse in cycle 0 → `pixel_en` in cycles 4, 8, 12 with `pixel_idx` 0, 1, 2; `sync`=`done`=1 in cycle 13 only; `busy` high in cycles 1..13.
- Zero length: `curr_length`=0, `start` → `sync`/`done`/`busy` high in cycle 1 only; `pixel_en` never asserts.
- Maximum length, TICK_DIV=1: `curr_length`=127 → `pixel_en` high in cycles 1..127 with `pixel_idx` 0..126 in order; `sync` in cycle 128; `idx` does not wrap.
- Ignored inputs, TICK_DIV=4: `curr_length`=2, `start` in cycle 0; then `start` again in cycle 3 and `curr_length` changed to 9 in cycle 2 → exactly 2 pixels (cycles 4, 8); `sync` in cycle 9; no second playback.
- Reset mid-run: `curr_length`=5, TICK_DIV=4, `nrst` low in cycle 6 → all outputs 0 immediately; no `sync` or `done`. After release, a new `start` with `curr_length`=1 gives one `pixel_en` with `pixel_idx`=0, 4 cycles after the start cycle, then `sync` in the following cycle.
- Back-to-back: `curr_length`=1, TICK_DIV=2, starts in cycles 0 and 4 → `pixel_en` in cycles 2 and 6; `sync` in cycles 3 and 7; both playbacks complete.

Source files
------------

// File: rtl/length_playback.sv
// Plays a latched length out as evenly spaced, indexed pixel-enable strobes,
// then pulses done/sync for one cycle to clear the upstream length counter.
module length_playback #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [6:0] curr_length,
    output logic       pixel_en,
    output logic [6:0] pixel_idx,
    output logic       busy,
    output logic       done,
    output logic       sync
);

    localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [6:0]      len_q, len_d;
    logic [6:0]      idx_q, idx_d;
    logic [DivW-1:0] div_q, div_d;
    logic            tick;

    assign tick = (state_q == StRun) && (div_q == DivMax);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        div_d   = div_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (curr_length != 7'd0) begin
                        len_d   = curr_length;
                        idx_d   = 7'd0;
                        div_d   = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                div_d = (div_q == DivMax) ? '0 : div_q + DivW'(1);
                if (tick) begin
                    // len_q is never 0 here, so len_q - 1 cannot underflow.
                    if (idx_q == len_q - 7'd1) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            len_q   <= 7'd0;
            idx_q   <= 7'd0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
        end
    end

    assign pixel_en  = tick;
    assign pixel_idx = idx_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign sync      = (state_q == StDone);

endmodule

// File: tb/tb_length_playback.sv
// Bench for length_playback: three instances (TICK_DIV 4, 1, 2) checked every cycle
// against a timing-formula model, plus literal expectations from hand-worked scenarios.
module tb_length_playback;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start_v [3];
    logic [6:0] len_v   [3];
    logic       pe      [3];
    logic [6:0] pidx    [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       sync_v  [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: per instance, the cycle its accepted start was sampled and its length.
    bit m_active [3] = '{0, 0, 0};
    int m_s0     [3] = '{0, 0, 0};
    int m_len    [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    length_playback #(.TICK_DIV(4)) dut_a (
        .clk(clk), .nrst(nrst), .start(start_v[0]), .curr_length(len_v[0]),
        .pixel_en(pe[0]), .pixel_idx(pidx[0]), .busy(busy_v[0]), .done(done_v[0]),
        .sync(sync_v[0])
    );
    length_playback #(.TICK_DIV(1)) dut_b (
        .clk(clk), .nrst(nrst), .start(start_v[1]), .curr_length(len_v[1]),
        .pixel_en(pe[1]), .pixel_idx(pidx[1]), .busy(busy_v[1]), .done(done_v[1]),
        .sync(sync_v[1])
    );
    length_playback #(.TICK_DIV(2)) dut_c (
        .clk(clk), .nrst(nrst), .start(start_v[2]), .curr_length(len_v[2]),
        .pixel_en(pe[2]), .pixel_idx(pidx[2]), .busy(busy_v[2]), .done(done_v[2]),
        .sync(sync_v[2])
    );

    function automatic int td(int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // A start is accepted only when the model says the instance is back in idle.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 3; i++) m_active[i] <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (start_v[i] &&
                    (!m_active[i] || (cyc - m_s0[i] >= m_len[i] * td(i) + 2))) begin
                    m_active[i] <= 1'b1;
                    m_s0[i]     <= cyc;
                    m_len[i]    <= int'(len_v[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int  t, p, tdv;
            bit  act, e_busy, e_pe, e_done;
            tdv    = td(i);
            t      = cyc - m_s0[i];
            p      = m_len[i] * tdv;
            act    = nrst && m_active[i];
            e_busy = act && t >= 1 && t <= p + 1;
            e_pe   = act && t >= tdv && t <= p && (t % tdv == 0);
            e_done = act && t == p + 1;
            check($sformatf("model_busy[%0d]", i), int'(busy_v[i]), int'(e_busy));
            check($sformatf("model_pixel_en[%0d]", i), int'(pe[i]), int'(e_pe));
            check($sformatf("model_done[%0d]", i), int'(done_v[i]), int'(e_done));
            check($sformatf("model_sync[%0d]", i), int'(sync_v[i]), int'(e_done));
            if (e_pe) check($sformatf("model_pixel_idx[%0d]", i), int'(pidx[i]), t / tdv - 1);
        end
    end

    task automatic goto(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(int i, logic [6:0] l);
        start_v[i] = 1'b1;
        len_v[i]   = l;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int b;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            len_v[i]   = 7'd0;
        end
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy_v[0]), 0);
        check("reset_idx", int'(pidx[0]), 0);
        nrst = 1'b1;
        goto(cyc + 1);
        check("post_reset_busy", int'(busy_v[1]), 0);

        // Basic playback, TICK_DIV=4, length 3.
        b = cyc + 2;
        goto(b);
        pulse(0, 7'd3);
        goto(b + 3);  check("basic_pe_c3", int'(pe[0]), 0);
        goto(b + 4);  check("basic_pe_c4", int'(pe[0]), 1);
        check("basic_idx_c4", int'(pidx[0]), 0);
        goto(b + 8);  check("basic_idx_c8", int'(pidx[0]), 1);
        goto(b + 12); check("basic_idx_c12", int'(pidx[0]), 2);
        check("basic_sync_c12", int'(sync_v[0]), 0);
        goto(b + 13); check("basic_sync_c13", int'(sync_v[0]), 1);
        check("basic_done_c13", int'(done_v[0]), 1);
        check("basic_busy_c13", int'(busy_v[0]), 1);
        goto(b + 14); check("basic_busy_c14", int'(busy_v[0]), 0);

        // Zero length.
        b = cyc + 2;
        goto(b);
        pulse(0, 7'd0);
        check("zero_sync_c1", int'(sync_v[0]), 1);
        check("zero_busy_c1", int'(busy_v[0]), 1);
        goto(b + 2);  check("zero_busy_c2", int'(busy_v[0]), 0);

        // Maximum length, TICK_DIV=1.
        b = cyc + 2;
        goto(b);
        pulse(1, 7'd127);
        check("max_pe_c1", int'(pe[1]), 1);
        check("max_idx_c1", int'(pidx[1]), 0);
        goto(b + 127); check("max_idx_c127", int'(pidx[1]), 126);
        goto(b + 128); check("max_sync_c128", int'(sync_v[1]), 1);
        check("max_pe_c128", int'(pe[1]), 0);

        // Ignored start and length change during a playback.
        b = cyc + 2;
        goto(b);
        pulse(0, 7'd2);
        goto(b + 2);  len_v[0] = 7'd9;
        goto(b + 3);  start_v[0] = 1'b1;
        goto(b + 4);  start_v[0] = 1'b0;
        check("ign_pe_c4", int'(pe[0]), 1);
        goto(b + 8);  check("ign_idx_c8", int'(pidx[0]), 1);
        goto(b + 9);  check("ign_sync_c9", int'(sync_v[0]), 1);
        goto(b + 10); check("ign_busy_c10", int'(busy_v[0]), 0);

        // Reset mid-run.
        b = cyc + 2;
        goto(b);
        pulse(0, 7'd5);
        goto(b + 5);
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        check("rst_busy_now", int'(busy_v[0]), 0);
        check("rst_pe_now", int'(pe[0]), 0);
        check("rst_idx_now", int'(pidx[0]), 0);
        goto(b + 8);  nrst = 1'b1;
        goto(b + 10); check("rst_sync_after", int'(sync_v[0]), 0);
        b = cyc + 1;
        goto(b);
        pulse(0, 7'd1);
        goto(b + 3);  check("rst_new_pe_c3", int'(pe[0]), 0);
        goto(b + 4);  check("rst_new_pe_c4", int'(pe[0]), 1);
        check("rst_new_idx_c4", int'(pidx[0]), 0);
        goto(b + 5);  check("rst_new_sync_c5", int'(sync_v[0]), 1);

        // Back-to-back, TICK_DIV=2, length 1.
        b = cyc + 2;
        goto(b);
        pulse(2, 7'd1);
        goto(b + 2);  check("b2b_pe_c2", int'(pe[2]), 1);
        goto(b + 3);  check("b2b_sync_c3", int'(sync_v[2]), 1);
        goto(b + 4);
        pulse(2, 7'd1);
        goto(b + 6);  check("b2b_pe_c6", int'(pe[2]), 1);
        goto(b + 7);  check("b2b_sync_c7", int'(sync_v[2]), 1);

        goto(cyc + 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
